// File: rtl/decum_pkg.sv
// Shared constants and FSM encoding for the windowed differencer (decum).
package decum_pkg;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_WINDOW = 2'd2
  } state_t;
endpackage

// File: rtl/decum_if.sv
// Sample/control bus of decum: master drives stream and controls, slave returns results.
interface decum_if
  import decum_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
);
  logic              run;
  logic              running;
  logic [DATA_W-1:0] in0;
  logic [CNT_W-1:0]  duty;
  logic [CNT_W-1:0]  delay0;
  logic [DATA_W-1:0] out0;
  logic              valid0;

  modport master (
    output run, running, in0, duty, delay0,
    input  out0, valid0
  );

  modport slave (
    input  run, running, in0, duty, delay0,
    output out0, valid0
  );
endinterface

// File: rtl/decum_win_ctrl.sv
// Start-delay and window counter FSM; tells the datapath when to consume a
// sample and when the following sample opens a fresh window.
module decum_win_ctrl
  import decum_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             running_i,
  input  logic [CNT_W-1:0] duty_i,
  input  logic [CNT_W-1:0] delay0_i,
  output logic             consume_o,
  output logic             window_start_o
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // window_start_o means "prev must be zero for the next consumed sample".
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    consume_o      = 1'b0;
    window_start_o = 1'b0;
    if (run_i) begin
      window_start_o = 1'b1;
      if (delay0_i != '0) begin
        state_d = ST_WAIT;
        cnt_d   = delay0_i;
      end else begin
        state_d = ST_WINDOW;
        cnt_d   = duty_i;
      end
    end else if (running_i) begin
      case (state_q)
        ST_WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d        = ST_WINDOW;
            cnt_d          = duty_i;
            window_start_o = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_WINDOW: begin
          consume_o = 1'b1;
          if (cnt_q == '0) begin
            cnt_d          = duty_i;
            window_start_o = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/decum.sv
// Windowed differencer: inverse of the windowed accumulator. Emits
// in0 - prev per consumed sample, with prev reset to zero at each window start.
module decum
  import decum_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic   clk,
  input  logic   rst,
  decum_if.slave bus
);
  logic              consume, window_start;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] out0_q, out0_d;
  logic              valid0_q, valid0_d;

  decum_win_ctrl #(.CNT_W(CNT_W)) u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .run_i          (bus.run),
    .running_i      (bus.running),
    .duty_i         (bus.duty),
    .delay0_i       (bus.delay0),
    .consume_o      (consume),
    .window_start_o (window_start)
  );

  always_comb begin
    prev_d   = prev_q;
    out0_d   = out0_q;
    valid0_d = consume;
    if (consume) begin
      out0_d = bus.in0 - prev_q;
      prev_d = bus.in0;
    end
    if (window_start) prev_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= '0;
      out0_q   <= '0;
      valid0_q <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      out0_q   <= out0_d;
      valid0_q <= valid0_d;
    end
  end

  assign bus.out0   = out0_q;
  assign bus.valid0 = valid0_q;
endmodule

// File: tb/tb_decum.sv
// Scoreboard bench for decum: stimulus pushes expected results from a
// sample-position reference model; a negedge monitor pops and compares.
module tb_decum;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decum_if #(.DATA_W(DW), .CNT_W(CW)) b();

  decum #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] val;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            ecnt = 0;
  int            vec  = 0;
  int            miss = 0;
  logic [DW-1:0] held = '0;

  // Reference model: position of the next sample inside its window.
  bit            m_active = 1'b0;
  int            m_skip = 0, m_duty = 0, m_pos = 0;
  logic [DW-1:0] m_prev = '0;
  logic [CW-1:0] t_duty = '0, t_delay = '0;

  always @(posedge clk) ecnt <= ecnt + 1;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      #1;
      vec++;
      if (b.out0 !== '0 || b.valid0 !== 1'b0) begin
        miss++;
        $display("FAIL reset: out0=%h valid0=%b, required out0=0 valid0=0", b.out0, b.valid0);
      end
      sb.delete();
      held = '0;
    end else if (sb.size() > 0 && sb[0].due == ecnt) begin
      mon_e = sb.pop_front();
      vec++;
      if (b.valid0 !== 1'b1 || b.out0 !== mon_e.val) begin
        miss++;
        $display("FAIL result edge %0d: out0=%h valid0=%b, required out0=%h valid0=1",
                 ecnt, b.out0, b.valid0, mon_e.val);
      end
      held = mon_e.val;
    end else begin
      vec++;
      if (b.valid0 !== 1'b0 || b.out0 !== held) begin
        miss++;
        $display("FAIL idle edge %0d: out0=%h valid0=%b, required out0=%h valid0=0",
                 ecnt, b.out0, b.valid0, held);
      end
    end
  end

  task automatic cyc(input logic r, input logic rn, input logic [DW-1:0] x,
                     input bit ovr, input logic [DW-1:0] ov);
    logic [DW-1:0] e;
    @(posedge clk);
    #1;
    b.run = r; b.running = rn; b.in0 = x; b.duty = t_duty; b.delay0 = t_delay;
    if (r) begin
      m_active = 1'b1;
      m_prev   = '0;
      m_pos    = 0;
      m_skip   = int'(t_delay);
      if (m_skip == 0) m_duty = int'(t_duty);
    end else if (rn && m_active) begin
      if (m_skip > 0) begin
        m_skip--;
        if (m_skip == 0) m_duty = int'(t_duty);
      end else begin
        e = (m_pos == 0) ? x : x - m_prev;
        sb.push_back('{due: ecnt + 1, val: (ovr ? ov : e)});
        m_prev = x;
        if (m_pos == m_duty) begin
          m_pos  = 0;
          m_duty = int'(t_duty);
        end else begin
          m_pos++;
        end
      end
    end
  endtask

  task automatic go(input logic r, input logic rn, input logic [DW-1:0] x);
    cyc(r, rn, x, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1; b.run = 1'b0; b.running = 1'b0;
    m_active = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  logic [DW-1:0] s29[6] = '{32'd5, 32'd12, 32'd20, 32'd21, 32'd30, 32'd31};
  logic [DW-1:0] o, sum;
  int            k, guard;
  logic          rn;

  initial begin
    b.run = 1'b0; b.running = 1'b0; b.in0 = '0; b.duty = '0; b.delay0 = '0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // Basic windows: out0 = 5,7,8,1,30,1
    t_delay = 7'd2; t_duty = 7'd3;
    go(1, 1, $urandom); go(0, 1, $urandom); go(0, 1, $urandom);
    for (int i = 0; i < 6; i++) go(0, 1, s29[i]);

    // Same with a two-cycle stall after the second sample
    go(1, 1, $urandom); go(0, 1, $urandom); go(0, 1, $urandom);
    go(0, 1, s29[0]); go(0, 1, s29[1]);
    go(0, 0, $urandom); go(0, 0, $urandom);
    for (int i = 2; i < 6; i++) go(0, 1, s29[i]);

    // Modulo wrap: 3,1 -> 3, 0xFFFFFFFE
    t_delay = 7'd0; t_duty = 7'd1;
    go(1, 1, $urandom); go(0, 1, 32'd3); go(0, 1, 32'd1);

    // Restart mid-window clears prev
    t_duty = 7'd3;
    go(1, 1, $urandom); go(0, 1, 32'd5); go(0, 1, 32'd12); go(0, 1, 32'd20);
    go(1, 1, $urandom); go(0, 1, 32'd25); go(0, 1, 32'd26);

    // duty 0: every sample passes straight through
    t_duty = 7'd0;
    go(1, 1, $urandom);
    repeat (5) go(0, 1, $urandom);

    // duty changes mid-window only apply at the next window load
    t_duty = 7'd3; t_delay = 7'd1;
    go(1, 1, $urandom); go(0, 1, $urandom); go(0, 1, $urandom); go(0, 1, $urandom);
    t_duty = 7'd1;
    repeat (8) go(0, 1, $urandom);

    // Reset mid-window, then no output until the next run
    t_delay = 7'd0; t_duty = 7'd5;
    go(1, 1, $urandom);
    repeat (3) go(0, 1, $urandom);
    do_reset();
    repeat (6) go(0, 1, $urandom);

    // Random runs, stalls and parameter changes
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        t_duty  = 7'($urandom_range(0, 7));
        t_delay = 7'($urandom_range(0, 5));
      end
      go(($urandom_range(0, 24) == 0), ($urandom_range(0, 7) != 0), $urandom);
    end

    // Round trip: accumulate a random stream per window, expect the original back
    t_duty  = 7'($urandom_range(1, 6));
    t_delay = 7'($urandom_range(0, 4));
    go(1, 1, $urandom);
    k = 0; guard = 0; sum = '0;
    while (k < 1000 && guard < 3000) begin
      guard++;
      rn = ($urandom_range(0, 9) != 0);
      if (rn && m_active && m_skip == 0) begin
        o = $urandom;
        sum = ((k % (int'(t_duty) + 1)) == 0) ? o : sum + o;
        cyc(0, 1, sum, 1'b1, o);
        k++;
      end else begin
        cyc(0, rn, $urandom, 1'b0, '0);
      end
    end
    repeat (3) go(0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/decum.md
DECUM -- requirements
Module: decum

Interface
REQ-001 Parameter DATA_W, default 32, sample/result width.
REQ-002 Parameter CNT_W, default 7, width of duty/delay counters.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 run  input  1  single-cycle start pulse; restarts the unit.
REQ-006 running  input  1  global advance enable; low = stall.
REQ-007 in0  input  DATA_W  input sample stream (running sum per window).
REQ-008 duty  input  CNT_W  window length minus one, in samples.
REQ-009 delay0  input  CNT_W  samples skipped after run before first window.
REQ-010 out0  output  DATA_W  registered difference result.
REQ-011 valid0  output  1  high when out0 holds a fresh result.

Function
REQ-012 The unit SHALL be the inverse of the windowed accumulator: within each window out0 = in0 - prev, where prev is the previous sample of the same window and is 0 for the first sample of every window.
REQ-013 FSM states SHALL be IDLE, WAIT, WINDOW; reset state IDLE.
REQ-014 run in any state SHALL load cnt<=delay0, prev<=0, valid0<=0; next state WAIT if delay0!=0, else WINDOW with cnt<=duty.
REQ-015 run SHALL take priority over running and all other transitions in the same cycle.
REQ-016 IDLE: hold; out0, valid0 unchanged except valid0<=0.
REQ-017 WAIT with running=1: cnt decrements; when cnt==1 the next state SHALL be WINDOW with cnt<=duty, prev<=0.
REQ-018 WINDOW with running=1: consume in0; out0<=in0-prev; valid0<=1; prev<=in0; if cnt==0 then cnt<=duty and prev<=0 (new window), else cnt decrements.
REQ-019 First consumed sample SHALL be the in0 presented delay0+1 running cycles after the run cycle; duty==0 SHALL give out0==in0 every sample.
REQ-020 running=0 in any state SHALL freeze state, cnt, prev, out0; valid0<=0.
REQ-021 Subtraction SHALL be modulo 2^DATA_W (wrap, no saturation, no flags).
REQ-022 Latency sample-to-out0 SHALL be exactly 1 cycle; throughput one sample per running cycle.
REQ-023 duty and delay0 SHALL be sampled only when loaded (run or window restart); changes mid-window take effect at next load.

Reset
REQ-024 On rst: state=IDLE, cnt=0, prev=0, out0=0, valid0=0, immediately and independent of clk.
REQ-025 rst asserted mid-window SHALL discard the window; after release the unit stays IDLE until run.

Structure
REQ-026 Package decum_pkg SHALL hold the FSM state encoding and default DATA_W/CNT_W constants.
REQ-027 Counter/FSM logic SHALL be one sub-module decum_win_ctrl (outputs: consume, window_start); datapath (prev, subtractor, out0) stays in decum.

Verification
REQ-028 Reset: assert rst mid-operation -> out0=0, valid0=0 same cycle; no output until next run.
REQ-029 delay0=2, duty=3, running=1, run at t; in0 from t+3 = 5,12,20,21,30,31 -> out0 = 5,7,8,1,30,1 at t+4..t+9, valid0=1 each.
REQ-030 Wrap: delay0=0, duty=1, in0 = 3,1 -> out0 = 3, 0xFFFFFFFE.
REQ-031 Stall: as REQ-029 with running=0 for 2 cycles after sample 12 -> outputs unchanged in value/order, valid0=0 during stall, out0 held at 7.
REQ-032 Restart: run asserted while in WINDOW with prev=20, delay0=0, in0=25 next cycle -> out0=25 (prev cleared).
REQ-033 Round trip: random stream through windowed accumulator then decum with equal duty/delay0 -> recovers original stream, 1000 samples.
